wishbone_arbiter: RTL

Two-master, one-slave Wishbone arbiter. It shares the external memory bus (SRAM/flash controller) between the host loader (master 0) and the Levenshtein search engine (master 1). The arbiter uses round-robin grant with a zero-idle handover, and grant ownership lasts for a whole bus cycle. It sits between both masters' `wbm_*` buses and the memory controller's slave port.

---
 rtl/levenshtein_pkg.sv | 30 +++
 rtl/arbiter_watchdog.sv | 42 ++++
 rtl/wishbone_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/levenshtein_pkg.sv
// Shared types and constants for the Levenshtein search system's Wishbone fabric.
// Holds the arbiter state encoding and the round-robin pick function.
package levenshtein_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int   WB_DATA_WIDTH = 8;
    localparam logic MST_HOST      = 1'b0;
    localparam logic MST_ENGINE    = 1'b1;

    // On a tie the master that did not own the bus last wins.
    function automatic arb_state_t arbitrate(input logic req0, input logic req1, input logic last);
        arb_state_t pick;
        if (req0 && req1) begin
            pick = (last == MST_HOST) ? GNT1 : GNT0;
        end else if (req0) begin
            pick = GNT0;
        end else if (req1) begin
            pick = GNT1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arbiter_watchdog.sv
// Stall watchdog for the Wishbone arbiter: counts consecutive stalled strobe cycles
// and flags expiry combinationally in the cycle the limit is reached.
module arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stall_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // cnt_q holds the number of stalled cycles before the current one.
    assign expire_o = stall_i && (cnt_q == LIMIT);

    // Next count: cleared on grant change or any non-stalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (stall_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter (host loader / search engine) onto one slave.
// Optional stall watchdog compiled in with the macro WB_ARBITER_TIMEOUT_EN.
module wishbone_arbiter
    import levenshtein_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [ADDR_WIDTH-1:0]    m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    output logic                     m0_rty_o,
    output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [ADDR_WIDTH-1:0]    m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic                     m1_rty_o,
    output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [ADDR_WIDTH-1:0]    s_adr_o,
    output logic [WB_DATA_WIDTH-1:0] s_dat_o,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_rty_i,
    input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
    output logic [1:0]               gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       expire_s;
    logic       g_cyc_s, g_stb_s, g_we_s;
    logic [ADDR_WIDTH-1:0]    g_adr_s;
    logic [WB_DATA_WIDTH-1:0] g_dat_s;
    logic       term_s, gnt0_s, gnt1_s;

    assign gnt0_s = (state_q == GNT0);
    assign gnt1_s = (state_q == GNT1);
    assign term_s = s_ack_i | s_err_i | s_rty_i;

    // Mux the granted master's request onto the slave side; IDLE drives zeros.
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_adr_s = '0;
        g_dat_s = '0;
        case (state_q)
            GNT0: begin
                g_cyc_s = m0_cyc_i;
                g_stb_s = m0_stb_i;
                g_we_s  = m0_we_i;
                g_adr_s = m0_adr_i;
                g_dat_s = m0_dat_i;
            end
            GNT1: begin
                g_cyc_s = m1_cyc_i;
                g_stb_s = m1_stb_i;
                g_we_s  = m1_we_i;
                g_adr_s = m1_adr_i;
                g_dat_s = m1_dat_i;
            end
            default: begin
                g_cyc_s = 1'b0;
            end
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    logic stall_s, grant_chg_s;
    assign stall_s     = g_stb_s & ~term_s;
    assign grant_chg_s = (state_d != state_q);

    arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_i (stall_s),
        .clr_i   (grant_chg_s),
        .expire_o(expire_s)
    );
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^8'(TIMEOUT_CYCLES);
    assign expire_s         = 1'b0;
`endif

    // An expiring cycle is withdrawn from the slave and errored back to the master.
    assign s_cyc_o = g_cyc_s & ~expire_s;
    assign s_stb_o = g_stb_s & ~expire_s;
    assign s_we_o  = g_we_s;
    assign s_adr_o = g_adr_s;
    assign s_dat_o = g_dat_s;

    assign m0_ack_o = gnt0_s & m0_cyc_i & s_ack_i;
    assign m0_err_o = gnt0_s & m0_cyc_i & (s_err_i | expire_s);
    assign m0_rty_o = gnt0_s & m0_cyc_i & s_rty_i;
    assign m1_ack_o = gnt1_s & m1_cyc_i & s_ack_i;
    assign m1_err_o = gnt1_s & m1_cyc_i & (s_err_i | expire_s);
    assign m1_rty_o = gnt1_s & m1_cyc_i & s_rty_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = {gnt1_s, gnt0_s};

    // Grant FSM: hold while the owner keeps cyc, re-arbitrate on the edge it drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_q);
            GNT0: begin
                if (expire_s) begin
                    state_d = IDLE;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else begin
                    state_d = arbitrate(1'b0, m1_cyc_i, last_q);
                end
            end
            GNT1: begin
                if (expire_s) begin
                    state_d = IDLE;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = arbitrate(m0_cyc_i, 1'b0, last_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remember the most recently granted master for tie-breaking.
    always_comb begin
        last_d = last_q;
        if ((state_d == GNT0) && (state_q != GNT0)) begin
            last_d = MST_HOST;
        end else if ((state_d == GNT1) && (state_q != GNT1)) begin
            last_d = MST_ENGINE;
        end else begin
            last_d = last_q;
        end
    end

    // State registers; reset favours the host on the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= MST_ENGINE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
